// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory request at a time, with store lane
// steering, misalignment detection and load-result extraction/extension.
module lsu (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   input  logic [2:0]  info_load,
   input  logic [1:0]  info_store,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [4:0]  dstreg_num,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic [4:0]  wb_reg,
   output logic [31:0] wb_data,
   output logic        misaligned
);

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_wstrb;
   logic [31:0] r_mem_wdata;
   logic [2:0]  r_ld_type;
   logic [1:0]  r_ld_off;
   logic        r_is_load;
   logic [4:0]  r_dst;
   logic        r_wb_valid;
   logic [4:0]  r_wb_reg;
   logic [31:0] r_wb_data;
   logic        r_misaligned;

   logic        w_accept;
   logic        w_ack;
   logic        w_is_load;
   logic        w_is_store;
   logic        w_mis;
   logic        w_issue;
   logic        w_mis_pulse;

   function automatic logic [31:0] store_lanes(input logic [1:0] st, input logic [31:0] sd);
      case (st)
         2'b00:   store_lanes = {4{sd[7:0]}};
         2'b01:   store_lanes = {2{sd[15:0]}};
         default: store_lanes = sd;
      endcase
   endfunction

   function automatic logic [3:0] store_strb(input logic [1:0] st, input logic [1:0] off);
      case (st)
         2'b00:   store_strb = 4'b0001 << off;
         2'b01:   store_strb = off[1] ? 4'b1100 : 4'b0011;
         2'b10:   store_strb = 4'b1111;
         default: store_strb = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] ld, input logic [1:0] off,
                                               input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[{off, 3'b000} +: 8];
      h = off[1] ? rd[31:16] : rd[15:0];
      case (ld)
         3'b000:  load_extend = {{24{b[7]}}, b};
         3'b001:  load_extend = {{16{h[15]}}, h};
         3'b100:  load_extend = {24'h000000, b};
         3'b101:  load_extend = {16'h0000, h};
         default: load_extend = rd;
      endcase
   endfunction

   // Op decode: a load encoding takes priority over a store encoding in the same op.
   always_comb begin
      w_is_load  = (info_load != 3'b111);
      w_is_store = 1'b0;
      w_mis      = 1'b0;
      if (w_is_load) begin
         w_mis = ((info_load[1:0] == 2'b01) && addr[0]) ||
                 ((info_load[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      end else begin
         w_is_store = (info_store != 2'b11);
         w_mis      = w_is_store &&
                      (((info_store == 2'b01) && addr[0]) ||
                       ((info_store == 2'b10) && (addr[1:0] != 2'b00)));
      end
   end

   assign w_ack       = (r_state == ST_WAIT) && mem_ack;
   assign w_accept    = in_valid && ((r_state == ST_IDLE) || mem_ack);
   assign w_issue     = w_accept && (w_is_load || w_is_store) && !w_mis;
   assign w_mis_pulse = w_accept && w_mis;

   // Next state: a new issue always lands in WAIT, even straight off an ack.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_issue) w_state_nxt = ST_WAIT;
            else         w_state_nxt = ST_IDLE;
         end
         ST_WAIT: begin
            if (w_issue)       w_state_nxt = ST_WAIT;
            else if (mem_ack)  w_state_nxt = ST_IDLE;
            else               w_state_nxt = ST_WAIT;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Request and op-context capture; held untouched until the next issue.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'h0000_0000;
         r_mem_wstrb <= 4'b0000;
         r_mem_wdata <= 32'h0000_0000;
         r_ld_type   <= 3'b111;
         r_ld_off    <= 2'b00;
         r_is_load   <= 1'b0;
         r_dst       <= 5'd0;
      end else if (w_issue) begin
         r_mem_we    <= w_is_store;
         r_mem_addr  <= {addr[31:2], 2'b00};
         r_mem_wstrb <= w_is_store ? store_strb(info_store, addr[1:0]) : 4'b0000;
         r_mem_wdata <= w_is_store ? store_lanes(info_store, store_data) : 32'h0000_0000;
         r_ld_type   <= info_load;
         r_ld_off    <= addr[1:0];
         r_is_load   <= w_is_load;
         r_dst       <= dstreg_num;
      end else begin
         r_mem_we    <= r_mem_we;
      end
   end

   // Writeback and misalignment pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wb_valid   <= 1'b0;
         r_wb_reg     <= 5'd0;
         r_wb_data    <= 32'h0000_0000;
         r_misaligned <= 1'b0;
      end else begin
         r_wb_valid   <= w_ack && r_is_load;
         r_misaligned <= w_mis_pulse;
         if (w_ack && r_is_load) begin
            r_wb_reg  <= r_dst;
            r_wb_data <= load_extend(r_ld_type, r_ld_off, mem_rdata);
         end else begin
            r_wb_reg  <= r_wb_reg;
         end
      end
   end

   assign stall      = (r_state == ST_WAIT) && !mem_ack;
   assign mem_req    = (r_state == ST_WAIT);
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wstrb  = r_mem_wstrb;
   assign mem_wdata  = r_mem_wdata;
   assign wb_valid   = r_wb_valid;
   assign wb_reg     = r_wb_reg;
   assign wb_data    = r_wb_data;
   assign misaligned = r_misaligned;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: each task drives one scenario and checks inline.
module tb_lsu;
   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic [2:0]  info_load;
   logic [1:0]  info_store;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [4:0]  dstreg_num;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        misaligned;

   int tests_run    = 0;
   int tests_failed = 0;

   lsu dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .info_load(info_load),
      .info_store(info_store), .addr(addr), .store_data(store_data),
      .dstreg_num(dstreg_num), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
      .wb_reg(wb_reg), .wb_data(wb_data), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid   = 1'b0;
      info_load  = 3'b111;
      info_store = 2'b11;
      addr       = 32'h0;
      store_data = 32'h0;
      dstreg_num = 5'd0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle_inputs();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      #3;
      tests_run++;
      if ({mem_req, mem_we, wb_valid, misaligned, stall} !== 5'b00000) begin
         tests_failed++;
         $display("FAIL reset_ctl: got %b exp 00000", {mem_req, mem_we, wb_valid, misaligned, stall});
      end
      tests_run++;
      if ({mem_addr, mem_wdata, wb_data, mem_wstrb, wb_reg} !== 105'd0) begin
         tests_failed++;
         $display("FAIL reset_data: addr=%h wdata=%h wbdata=%h strb=%b reg=%0d exp all 0",
                  mem_addr, mem_wdata, wb_data, mem_wstrb, wb_reg);
      end
      step(); step();
      rstn = 1'b1;
      step();
   endtask

   task automatic test_lb();
      in_valid = 1'b1; info_load = 3'b000; addr = 32'h103; dstreg_num = 5'd7;
      step();
      in_valid = 1'b0; info_load = 3'b111; addr = 32'hDEAD_BEEF;
      #2;
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wstrb !== 4'b0000) begin
         tests_failed++;
         $display("FAIL lb_req: req=%b addr=%h we=%b strb=%b exp 1 00000100 0 0000",
                  mem_req, mem_addr, mem_we, mem_wstrb);
      end
      tests_run++;
      if (stall !== 1'b1) begin tests_failed++; $display("FAIL lb_stall1: got %b exp 1", stall); end
      step();
      #2;
      tests_run++;
      if (stall !== 1'b1 || mem_addr !== 32'h100) begin
         tests_failed++;
         $display("FAIL lb_stall2: stall=%b addr=%h exp 1 00000100", stall, mem_addr);
      end
      step();
      mem_ack = 1'b1; mem_rdata = 32'h80FF_FFFF;
      #2;
      tests_run++;
      if (stall !== 1'b0 || mem_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL lb_ackcyc: stall=%b req=%b exp 0 1", stall, mem_req);
      end
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      #2;
      tests_run++;
      if (wb_valid !== 1'b1 || wb_reg !== 5'd7 || wb_data !== 32'hFFFF_FF80) begin
         tests_failed++;
         $display("FAIL lb_wb: valid=%b reg=%0d data=%h exp 1 7 ffffff80", wb_valid, wb_reg, wb_data);
      end
      tests_run++;
      if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL lb_done: req=%b exp 0", mem_req); end
      step();
      #2;
      tests_run++;
      if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL lb_pulse: wb_valid=%b exp 0", wb_valid); end
   endtask

   task automatic test_sh();
      in_valid = 1'b1; info_store = 2'b01; addr = 32'h202; store_data = 32'h1234_ABCD;
      step();
      idle_inputs();
      mem_ack = 1'b1;
      #2;
      tests_run++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 ||
          mem_wstrb !== 4'b1100 || mem_wdata !== 32'hABCD_ABCD) begin
         tests_failed++;
         $display("FAIL sh_req: req=%b we=%b addr=%h strb=%b wdata=%h exp 1 1 00000200 1100 abcdabcd",
                  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata);
      end
      tests_run++;
      if (stall !== 1'b0) begin tests_failed++; $display("FAIL sh_stall: got %b exp 0", stall); end
      step();
      mem_ack = 1'b0;
      #2;
      tests_run++;
      if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL sh_done: req=%b wb_valid=%b exp 0 0", mem_req, wb_valid);
      end
   endtask

   task automatic test_sb_lh();
      in_valid = 1'b1; info_store = 2'b00; addr = 32'h0000_0013; store_data = 32'h0000_005A;
      step();
      idle_inputs();
      mem_ack = 1'b1;
      #2;
      tests_run++;
      if (mem_wstrb !== 4'b1000 || mem_wdata !== 32'h5A5A_5A5A || mem_addr !== 32'h10) begin
         tests_failed++;
         $display("FAIL sb_lane: strb=%b wdata=%h addr=%h exp 1000 5a5a5a5a 00000010",
                  mem_wstrb, mem_wdata, mem_addr);
      end
      in_valid = 1'b1; info_load = 3'b001; addr = 32'h12; dstreg_num = 5'd21;
      step();
      idle_inputs();
      mem_ack = 1'b1; mem_rdata = 32'h9ABC_0000;
      step();
      mem_ack = 1'b0;
      #2;
      tests_run++;
      if (wb_valid !== 1'b1 || wb_reg !== 5'd21 || wb_data !== 32'hFFFF_9ABC) begin
         tests_failed++;
         $display("FAIL lh_wb: valid=%b reg=%0d data=%h exp 1 21 ffff9abc", wb_valid, wb_reg, wb_data);
      end
      step();
   endtask

   task automatic test_misaligned();
      in_valid = 1'b1; info_load = 3'b010; addr = 32'h301; dstreg_num = 5'd4;
      step();
      idle_inputs();
      #2;
      tests_run++;
      if (misaligned !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL mis_pulse: mis=%b req=%b wb=%b exp 1 0 0", misaligned, mem_req, wb_valid);
      end
      in_valid = 1'b1;
      step();
      idle_inputs();
      #2;
      tests_run++;
      if (misaligned !== 1'b0 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL noop: mis=%b req=%b wb=%b exp 0 0 0", misaligned, mem_req, wb_valid);
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; info_load = 3'b101; addr = 32'h40; dstreg_num = 5'd3;
      step();
      idle_inputs();
      #2;
      tests_run++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_wstrb !== 4'b0000) begin
         tests_failed++;
         $display("FAIL b2b_first: req=%b addr=%h strb=%b exp 1 00000040 0000", mem_req, mem_addr, mem_wstrb);
      end
      step();
      in_valid = 1'b1; info_store = 2'b10; addr = 32'h44; store_data = 32'hCAFE_F00D;
      mem_ack = 1'b1; mem_rdata = 32'h1234_8765;
      #2;
      tests_run++;
      if (stall !== 1'b0) begin tests_failed++; $display("FAIL b2b_stall: got %b exp 0", stall); end
      step();
      idle_inputs();
      mem_ack = 1'b0;
      #2;
      tests_run++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h44 ||
          mem_wstrb !== 4'b1111 || mem_wdata !== 32'hCAFE_F00D) begin
         tests_failed++;
         $display("FAIL b2b_second: req=%b we=%b addr=%h strb=%b wdata=%h exp 1 1 00000044 1111 cafef00d",
                  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata);
      end
      tests_run++;
      if (wb_valid !== 1'b1 || wb_reg !== 5'd3 || wb_data !== 32'h0000_8765) begin
         tests_failed++;
         $display("FAIL b2b_wb: valid=%b reg=%0d data=%h exp 1 3 00008765", wb_valid, wb_reg, wb_data);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      #2;
      tests_run++;
      if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_done: req=%b wb=%b exp 0 0", mem_req, wb_valid);
      end
   endtask

   task automatic test_reset_wait();
      in_valid = 1'b1; info_load = 3'b010; addr = 32'h500; dstreg_num = 5'd9;
      step();
      idle_inputs();
      #2;
      tests_run++;
      if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL rw_req: got %b exp 1", mem_req); end
      rstn = 1'b0;
      #1;
      tests_run++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
         tests_failed++;
         $display("FAIL rw_async: req=%b addr=%h exp 0 00000000", mem_req, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
      step();
      rstn = 1'b1;
      step();
      #2;
      tests_run++;
      if (mem_req !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL rw_ignore: req=%b wb=%b stall=%b exp 0 0 0", mem_req, wb_valid, stall);
      end
      mem_ack = 1'b0;
      step();
      #2;
      tests_run++;
      if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_nowb: got %b exp 0", wb_valid); end
   endtask

   initial begin
      test_reset();
      test_lb();
      test_sh();
      test_sb_lh();
      test_misaligned();
      test_back_to_back();
      test_reset_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rstn  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  op presented by the previous stage this cycle.
REQ-005 info_load  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101, NOTLOAD=111.
REQ-006 info_store  in  2  Sb=00, Sh=01, Sw=10, NOTSTORE=11.
REQ-007 addr  in  32  effective byte address (rs1+imm).
REQ-008 store_data  in  32  rs2 value.
REQ-009 dstreg_num  in  5  load destination register.
REQ-010 stall  out  1  pipeline hold request, combinational.
REQ-011 mem_req  out  1  data-memory request, registered.
REQ-012 mem_we  out  1  1=write, 0=read, registered.
REQ-013 mem_addr  out  32  word address {addr[31:2],2'b00}, registered.
REQ-014 mem_wstrb  out  4  byte-lane write enables, registered.
REQ-015 mem_wdata  out  32  lane-replicated store data, registered.
REQ-016 mem_rdata  in  32  read word, valid when mem_ack=1.
REQ-017 mem_ack  in  1  transaction complete, sampled only while mem_req=1.
REQ-018 wb_valid  out  1  one-cycle load-result pulse.
REQ-019 wb_reg  out  5  load destination register.
REQ-020 wb_data  out  32  extended load result.
REQ-021 misaligned  out  1  one-cycle misaligned-access pulse.

Function
REQ-022 States SHALL be IDLE and WAIT; mem_req=1 exactly when state=WAIT.
REQ-023 accept SHALL equal in_valid && (state==IDLE || (state==WAIT && mem_ack)).
REQ-024 A memory op is info_load!=NOTLOAD or info_store!=NOTSTORE; both inactive means accept is a no-op: no request, no pulse.
REQ-025 Misaligned cases are LH/LHU/Sh with addr[0]=1 and LW/Sw with addr[1:0]!=0.
REQ-026 An accepted aligned op SHALL cause, next cycle: state=WAIT, mem_req=1, and mem_addr/mem_we/mem_wstrb/mem_wdata latched.
REQ-027 An accepted misaligned op SHALL produce misaligned=1 for one cycle next cycle, with no request and state IDLE (or leaving WAIT).
REQ-028 Request outputs SHALL stay stable from the first cycle of WAIT through the cycle mem_ack=1.
REQ-029 stall SHALL equal (state==WAIT && !mem_ack).
REQ-030 On ack with no accept, the next cycle SHALL have state IDLE and mem_req=0.
REQ-031 On ack with a simultaneous accept, the new request SHALL issue next cycle with no idle gap.
REQ-032 Store lanes: Sb gives wdata={4{sd[7:0]}}, wstrb=0001<<addr[1:0]; Sh gives wdata={2{sd[15:0]}}, wstrb=addr[1]?1100:0011; Sw gives wdata=sd, wstrb=1111.
REQ-033 For loads, mem_we=0 and wstrb=0000.
REQ-034 Load ack SHALL set wb_valid=1 next cycle for one cycle, with wb_reg=latched dstreg_num.
REQ-035 wb_data selects byte addr[1:0] or half addr[1] of mem_rdata, sign-extended for LB/LH, zero-extended for LBU/LHU; LW passes the full word.
REQ-036 Store ack SHALL produce no wb_valid.
REQ-037 Minimum latency: accept at cycle 0, ack at cycle 1, wb_valid at cycle 2.
REQ-038 The addr/info_load/info_store offsets SHALL be latched at accept; later input changes SHALL have no effect.

Reset
REQ-039 rstn=0 SHALL immediately force state=IDLE and mem_req, mem_we, wb_valid, misaligned=0; wb_reg, mem_addr, mem_wstrb, mem_wdata, wb_data=0.
REQ-040 Reset mid-WAIT SHALL abandon the transaction with no wb_valid; a mem_ack arriving after reset SHALL be ignored.

Verification
REQ-041 LB at addr=0x103, ack after 3 cycles with rdata=0x80FF_FF_FF -> mem_addr=0x100, stall=1 for 2 cycles, wb_data=0xFFFFFF80.
REQ-042 Sh at addr=0x202, sd=0x1234ABCD, ack same cycle as req -> wstrb=1100, wdata=0xABCDABCD, no wb_valid.
REQ-043 LW at 0x301 -> misaligned pulse, mem_req stays 0, no wb_valid.
REQ-044 LHU at 0x40 followed by Sw at 0x44 presented during the ack cycle -> mem_req stays high across the boundary, second mem_addr=0x44, wstrb=1111.
REQ-045 rstn low during WAIT, then mem_ack=1 -> mem_req=0 immediately, no wb_valid.
